// File: rtl/mult_pkg.sv
// Shared multiplier/accumulator package: default widths, clog2 helper,
// and the output-slot state type used by product_accumulator.
package mult_pkg;

  localparam int BW_DEF = 8;
  localparam int N_DEF  = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/product_accumulator_if.sv
// Product stream in / group sum out handshake bundle.
// master: product source + sum consumer; slave: the accumulator.
interface product_accumulator_if
  import mult_pkg::*;
#(
  parameter int bw = BW_DEF,
  parameter int N  = N_DEF
);
  localparam int AW = 2*bw + clog2(N);

  logic [2*bw-1:0] prod_in;
  logic            prod_valid;
  logic            prod_ready;
  logic            clear;
  logic [AW-1:0]   sum_out;
  logic            sum_valid;
  logic            sum_ready;
  logic            busy;

  modport master (
    output prod_in, prod_valid, clear, sum_ready,
    input  prod_ready, sum_out, sum_valid, busy
  );

  modport slave (
    input  prod_in, prod_valid, clear, sum_ready,
    output prod_ready, sum_out, sum_valid, busy
  );

endinterface

// File: rtl/product_accumulator.sv
// Sums every N accepted products; one-slot registered result output.
// Ports: CLK, RESETn (async low), io (slave: products in, sums out).
module product_accumulator
  import mult_pkg::*;
#(
  parameter int bw = BW_DEF,
  parameter int N  = N_DEF
) (
  input logic                  CLK,
  input logic                  RESETn,
  product_accumulator_if.slave io
);

  localparam int CW = clog2(N);
  localparam int AW = 2*bw + CW;

  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [AW-1:0] prod_ext;
  logic [AW-1:0] acc_nxt;
  logic [AW-1:0] sum_r;
  out_state_t    state;
  out_state_t    state_nxt;
  logic          cnt_last;
  logic          rdy;
  logic          accept;
  logic          done;
  logic          xfer;

  assign prod_ext = {{CW{1'b0}}, io.prod_in};
  assign acc_nxt  = acc + prod_ext;
  assign cnt_last = (cnt == CW'(N-1));
  assign accept   = io.prod_valid && rdy;
  assign done     = accept && cnt_last && !io.clear;
  assign xfer     = (state == OUT_FULL) && io.sum_ready;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= OUT_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      OUT_EMPTY: if (done) state_nxt = OUT_FULL;
      OUT_FULL:  if (xfer && !done) state_nxt = OUT_EMPTY;
      default:   state_nxt = OUT_EMPTY;
    endcase
  end

  // Ready stalls only the group-completing product while the slot is full.
  always_comb begin
    rdy          = !((state == OUT_FULL) && cnt_last);
    io.prod_ready = rdy;
    io.sum_valid  = (state == OUT_FULL);
    io.busy       = (cnt != '0) || (state == OUT_FULL);
    io.sum_out    = sum_r;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      acc   <= '0;
      cnt   <= '0;
      sum_r <= '0;
    end else if (io.clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (cnt_last) begin
        sum_r <= acc_nxt;
        acc   <= '0;
        cnt   <= '0;
      end else begin
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator (bw=8, N=4): vector table,
// directed multi-cycle sequences and random traffic against a queue model.
module tb_product_accumulator;
  import mult_pkg::*;

  localparam int BW = 8;
  localparam int NN = 4;
  localparam int AW = 2*BW + clog2(NN);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  product_accumulator_if #(.bw(BW), .N(NN)) io();

  product_accumulator #(.bw(BW), .N(NN)) dut (
    .CLK   (clk),
    .RESETn(rst_n),
    .io    (io)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list of products in the open group, one result slot.
  int            part[$];
  logic [AW-1:0] m_out;
  bit            m_full;

  function automatic bit m_ready();
    return !(m_full && part.size() == NN-1);
  endfunction

  function automatic bit m_busy();
    return (part.size() != 0) || m_full;
  endfunction

  task automatic m_reset();
    part.delete();
    m_full = 1'b0;
    m_out  = '0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".prod_ready"}, 32'(io.prod_ready), 32'(m_ready()));
    chk({tag, ".sum_valid"},  32'(io.sum_valid),  32'(m_full));
    chk({tag, ".sum_out"},    32'(io.sum_out),    32'(m_out));
    chk({tag, ".busy"},       32'(io.busy),       32'(m_busy()));
  endtask

  // Drive one cycle from a negedge, advance the model at the posedge,
  // return at the next negedge.
  task automatic step(input bit v, input logic [15:0] p, input bit c,
                      input bit r);
    bit rdy;
    int s;
    rdy = m_ready();
    io.prod_valid = v;
    io.prod_in    = p;
    io.clear      = c;
    io.sum_ready  = r;
    @(posedge clk);
    if (m_full && r) m_full = 1'b0;
    if (c) begin
      part.delete();
    end else if (v && rdy) begin
      part.push_back(int'(p));
      if (part.size() == NN) begin
        s = 0;
        foreach (part[i]) s += part[i];
        m_out  = AW'(s);
        m_full = 1'b1;
        part.delete();
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    bit          v;
    logic [15:0] p;
    bit          c;
    bit          r;
    bit          e_sv;
    logic [17:0] e_sum;
    bit          e_rdy;
    bit          e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit v, input logic [15:0] p,
                              input bit c, input bit r, input bit sv,
                              input logic [17:0] sm, input bit rd,
                              input bit bz);
    vec_t t;
    t.v = v; t.p = p; t.c = c; t.r = r;
    t.e_sv = sv; t.e_sum = sm; t.e_rdy = rd; t.e_busy = bz;
    return t;
  endfunction

  initial begin
    io.prod_valid = 1'b0;
    io.prod_in    = '0;
    io.clear      = 1'b0;
    io.sum_ready  = 1'b0;
    m_reset();

    // basic 1+2+3+4
    tbl.push_back(mk(1, 16'h0001, 0, 1, 0, 18'd0,  1, 1));
    tbl.push_back(mk(1, 16'h0002, 0, 1, 0, 18'd0,  1, 1));
    tbl.push_back(mk(1, 16'h0003, 0, 1, 0, 18'd0,  1, 1));
    tbl.push_back(mk(1, 16'h0004, 0, 1, 1, 18'd10, 1, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 18'd10, 1, 0));
    // max products, no wrap, then a zero group
    tbl.push_back(mk(1, 16'hFE01, 0, 1, 0, 18'd10, 1, 1));
    tbl.push_back(mk(1, 16'hFE01, 0, 1, 0, 18'd10, 1, 1));
    tbl.push_back(mk(1, 16'hFE01, 0, 1, 0, 18'd10, 1, 1));
    tbl.push_back(mk(1, 16'hFE01, 0, 1, 1, 18'h3F804, 1, 1));
    tbl.push_back(mk(1, 16'h0000, 0, 1, 0, 18'h3F804, 1, 1));
    tbl.push_back(mk(1, 16'h0000, 0, 1, 0, 18'h3F804, 1, 1));
    tbl.push_back(mk(1, 16'h0000, 0, 1, 0, 18'h3F804, 1, 1));
    tbl.push_back(mk(1, 16'h0000, 0, 1, 1, 18'd0, 1, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 18'd0, 1, 0));
    // clear wins over a simultaneous accept
    tbl.push_back(mk(1, 16'h0005, 0, 1, 0, 18'd0, 1, 1));
    tbl.push_back(mk(1, 16'h0006, 0, 1, 0, 18'd0, 1, 1));
    tbl.push_back(mk(1, 16'h0007, 1, 1, 0, 18'd0, 1, 0));
    tbl.push_back(mk(1, 16'h0001, 0, 1, 0, 18'd0, 1, 1));
    tbl.push_back(mk(1, 16'h0001, 0, 1, 0, 18'd0, 1, 1));
    tbl.push_back(mk(1, 16'h0001, 0, 1, 0, 18'd0, 1, 1));
    tbl.push_back(mk(1, 16'h0001, 0, 1, 1, 18'd4, 1, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 18'd4, 1, 0));

    repeat (2) @(negedge clk);
    chk("reset.prod_ready", 32'(io.prod_ready), 32'd1);
    chk("reset.sum_valid",  32'(io.sum_valid),  32'd0);
    chk("reset.sum_out",    32'(io.sum_out),    32'd0);
    chk("reset.busy",       32'(io.busy),       32'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].p, tbl[i].c, tbl[i].r);
      chk($sformatf("tbl%0d.sum_valid", i), 32'(io.sum_valid),
          32'(tbl[i].e_sv));
      chk($sformatf("tbl%0d.sum_out", i), 32'(io.sum_out),
          32'(tbl[i].e_sum));
      chk($sformatf("tbl%0d.prod_ready", i), 32'(io.prod_ready),
          32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d.busy", i), 32'(io.busy), 32'(tbl[i].e_busy));
    end

    // backpressure: 8 x 0x10 with the consumer stalled
    for (int i = 0; i < 7; i++) step(1, 16'h0010, 0, 0);
    chk("bp.sum_valid", 32'(io.sum_valid), 32'd1);
    chk("bp.sum_out",   32'(io.sum_out),   32'h40);
    chk("bp.stall",     32'(io.prod_ready), 32'd0);
    step(1, 16'h0010, 0, 0);
    chk("bp.held_out",  32'(io.sum_out),    32'h40);
    chk("bp.held_rdy",  32'(io.prod_ready), 32'd0);
    step(1, 16'h0010, 0, 1);
    chk("bp.xfer_valid", 32'(io.sum_valid),  32'd0);
    chk("bp.xfer_rdy",   32'(io.prod_ready), 32'd1);
    chk("bp.xfer_busy",  32'(io.busy),       32'd1);
    step(1, 16'h0010, 0, 1);
    chk("bp.second_valid", 32'(io.sum_valid), 32'd1);
    chk("bp.second_sum",   32'(io.sum_out),   32'h40);
    step(0, 16'h0000, 0, 1);
    chk("bp.drained", 32'(io.busy), 32'd0);

    // reset mid-group with a result pending
    for (int i = 0; i < 6; i++) step(1, 16'h0003, 0, 0);
    chk("rst.pending", 32'(io.sum_valid), 32'd1);
    io.prod_valid = 1'b0;
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    chk("rst.sum_valid",  32'(io.sum_valid),  32'd0);
    chk("rst.sum_out",    32'(io.sum_out),    32'd0);
    chk("rst.busy",       32'(io.busy),       32'd0);
    chk("rst.prod_ready", 32'(io.prod_ready), 32'd1);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) step(1, 16'h0002, 0, 1);
    chk("rst.after_valid", 32'(io.sum_valid), 32'd1);
    chk("rst.after_sum",   32'(io.sum_out),   32'd8);

    // multiplier stream A = B = 1..8
    for (int i = 1; i <= 8; i++) begin
      step(1, 16'(i*i), 0, 1);
      if (i == 4) chk("int.sum0", 32'(io.sum_out), 32'd30);
      if (i == 8) chk("int.sum1", 32'(io.sum_out), 32'd174);
    end
    step(0, 16'h0000, 0, 1);
    check_model("int");

    // random traffic, lightly then heavily backpressured
    for (int i = 0; i < 600; i++) begin
      check_model("rnd");
      step($urandom_range(0, 3) != 0, 16'($urandom),
           $urandom_range(0, 15) == 0,
           (i < 300) ? ($urandom_range(0, 3) != 0)
                     : ($urandom_range(0, 3) == 0));
    end
    check_model("rnd_end");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Downstream consumer of the pipelined array multiplier: takes its 2*bw-bit unsigned product stream, sums every N accepted products into one result, and presents each result on a valid/ready output port. A registered output slot lets accumulation of the next group continue while a finished result waits. The parent delays the operand-valid signal to match the multiplier pipeline latency and drives it as `prod_valid`.

## Interface
- `bw`, default 8: multiplier operand width; products are 2*bw bits.
- `N`, default 4: products per result; legal range 2..256.
- `AW`, derived as 2*bw + clog2(N) (18 at defaults): accumulator and result width; overflow is impossible by construction.

- `CLK`  in  1  single clock, rising edge.
- `RESETn`  in  1  asynchronous, active-low reset.
- `prod_in`  in  2*bw  unsigned product from the multiplier.
- `prod_valid`  in  1  `prod_in` is valid this cycle.
- `prod_ready`  out  1  block can accept a product this cycle.
- `clear`  in  1  synchronous abort of the partial group.
- `sum_out`  out  AW  completed group sum.
- `sum_valid`  out  1  `sum_out` holds an unconsumed result.
- `sum_ready`  in  1  consumer accepts `sum_out`.
- `busy`  out  1  partial group in progress or result pending.

## Operation
- Accept = `prod_valid` && `prod_ready`. Transfer = `sum_valid` && `sum_ready`.
- Accumulator register `acc` (AW bits) and group counter `cnt` (0..N-1):
  - Accept with `cnt` < N-1: `acc` <= `acc` + `prod_in`, `cnt` <= `cnt` + 1.
  - Accept with `cnt` = N-1: `sum_out` <= `acc` + `prod_in`, `acc` <= 0, `cnt` <= 0, `sum_valid` <= 1.
  - The addition zero-extends `prod_in` to AW bits.
- The output-slot FSM has two states:
  - OUT_EMPTY -> OUT_FULL on group completion.
  - OUT_FULL -> OUT_EMPTY on transfer without a completion in the same cycle.
- `prod_ready` = !(`sum_valid` && `cnt` == N-1). It is derived from registers only and has no combinational path from `sum_ready`. It stalls only the product that would complete a new group while the slot is occupied.
- `sum_out` is held stable while `sum_valid` = 1 and `sum_ready` = 0.
- `clear` = 1 sets `acc` <= 0 and `cnt` <= 0. It does not affect `sum_out` or `sum_valid`. If `clear` and an accept occur in the same cycle, `clear` wins and the product is discarded.
- `busy` = (`cnt` != 0) || `sum_valid`.

## Timing
- Reset values (asynchronous, while `RESETn` = 0):
  - `acc` = 0, `cnt` = 0, `sum_out` = 0, `sum_valid` = 0, FSM = OUT_EMPTY.
  - Outputs `prod_ready` = 1 and `busy` = 0.
- Reset asserted mid-group or with a result pending discards everything immediately. The first accept after `RESETn` rises starts a new group.
- Latency: `sum_valid` rises on the same edge that accepts the Nth product, i.e. it is visible the cycle after that product.
- Throughput: one product per cycle while `sum_ready` is held at 1.
  - When `cnt` = N-1 coincides with `sum_valid` = 1, there is a one-cycle bubble.
  - Sustained rate is N products per N+1 cycles in the worst case, and N per N cycles when the consumer drains the result before the next group completes.
- A transfer and a group completion can never fall on the same edge, because `prod_ready` is low in that case.

## Structure
- Shared package `mult_pkg`:
  - `clog2` constant function.
  - Output FSM state typedef (OUT_EMPTY, OUT_FULL).
  - Default `bw` and `N` constants, shared with the multiplier and its bench.
- No sub-module: one module with the counter, accumulator, output slot and FSM.

## Test plan
All scenarios use bw = 8, N = 4.
- Basic: feed 0x0001, 0x0002, 0x0003, 0x0004 on consecutive cycles with `sum_ready` = 1 -> `sum_out` = 10 and `sum_valid` = 1 for one cycle, the cycle after the 4th product.
- Max values: 4 × 0xFE01 -> `sum_out` = 0x3F804 with no wrap; a following group of 4 × 0x0000 yields 0.
- Backpressure: `sum_ready` = 0, stream 8 products of 0x0010 -> first `sum_out` = 0x40 held, `prod_ready` drops with `cnt` = 3. Raise `sum_ready` -> 0x40 transfers, the stalled product is accepted next cycle, and the second `sum_out` = 0x40.
- Clear: accept 0x0005, 0x0006, then assert `clear` together with a valid 0x0007 -> product discarded, `cnt` = 0. The next 4 × 0x0001 give `sum_out` = 4.
- Reset mid-operation: after 2 accepts with a result pending, pulse `RESETn` low between edges -> `sum_valid`, `sum_out`, `busy` all 0 immediately and `prod_ready` = 1. The next group of 4 × 0x0002 gives 8.
- Integration: drive the multiplier with A = B = 1..8 and aligned valid -> sums 30 (1+4+9+16) and 174 (25+36+49+64).
